spi_master_param: RTL and testbench

Parametrised SPI master: shifts a DATA_W-bit word out on mosi while capturing miso, with a programmable SCLK divider, all four CPOL/CPHA modes and NUM_SLAVES active-low chip selects. It sits between the host-side register logic (start/busy/done handshake) and the SPI pins, generating SCLK itself from the system clock. It replaces the fixed 8-bit, dual-edge, three-slave master with a single-edge, fully synchronous design.

---
 rtl/spi_master_param.sv | 219 +++++++++++++++++++++
 tb/tb_spi_master_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// Parametrised single-edge SPI master: all CPOL/CPHA modes, programmable SCLK divider, NUM_SLAVES chip selects.
// Defining SPIM_LSB_FIRST_EN adds the lsb_first port (LSB-first shift and receive); otherwise always MSB first.
module spi_master_param #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned NUM_SLAVES = 3,
   parameter int unsigned SEL_W      = 2,
   parameter int unsigned DIV_W      = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic [SEL_W-1:0]      slave_sel,
   input  logic [DIV_W-1:0]      clk_div,
   input  logic [DATA_W-1:0]     tx_data,
`ifdef SPIM_LSB_FIRST_EN
   input  logic                  lsb_first,
`endif
   output logic [DATA_W-1:0]     rx_data,
   output logic                  busy,
   output logic                  done,
   output logic                  sclk,
   output logic                  mosi,
   input  logic                  miso,
   output logic [NUM_SLAVES-1:0] cs_n
);

   localparam int unsigned HP_W    = $clog2(2 * DATA_W);
   localparam int unsigned HP_LAST = 2 * DATA_W - 1;

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_DONE} state_e;

   state_e                  state_q, state_d;
   logic [DIV_W:0]          cnt_q, cnt_d;
   logic [HP_W-1:0]         hp_q, hp_d;
   logic [DIV_W-1:0]        div_q, div_d;
   logic                    cpol_q, cpol_d;
   logic                    cpha_q, cpha_d;
   logic [DATA_W-1:0]       tx_sr_q, tx_sr_d;
   logic [DATA_W-1:0]       rx_sr_q, rx_sr_d;
   logic [DATA_W-1:0]       rx_data_q, rx_data_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    sclk_q, sclk_d;
   logic                    mosi_q, mosi_d;
   logic [NUM_SLAVES-1:0]   cs_n_q, cs_n_d;

   logic                    hp_tc;
   logic                    edge_en;
   logic [HP_W-1:0]         edge_idx;
   logic                    do_shift;
   logic                    lsb_start;
   logic                    lsb_cur;

`ifdef SPIM_LSB_FIRST_EN
   logic lsb_q, lsb_d;
   assign lsb_start = lsb_first;
   assign lsb_cur   = lsb_q;
`else
   assign lsb_start = 1'b0;
   assign lsb_cur   = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hp_d      = hp_q;
      div_d     = div_q;
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      rx_data_d = rx_data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      cs_n_d    = cs_n_q;
      edge_en   = 1'b0;
      edge_idx  = '0;
      do_shift  = 1'b0;
      hp_tc     = (cnt_q == {1'b0, div_q});
`ifdef SPIM_LSB_FIRST_EN
      lsb_d     = lsb_q;
`endif

      case (state_q)
         // DONE behaves like IDLE so a start in the done cycle is taken back-to-back
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cs_n_d  = '1;
            sclk_d  = cpol;
            if (start) begin
               state_d = S_SETUP;
               cnt_d   = '0;
               div_d   = clk_div;
               cpol_d  = cpol;
               cpha_d  = cpha;
               tx_sr_d = tx_data;
               rx_sr_d = '0;
               busy_d  = 1'b1;
               mosi_d  = lsb_start ? tx_data[0] : tx_data[DATA_W-1];
               for (int unsigned i = 0; i < NUM_SLAVES; i++)
                  cs_n_d[i] = (slave_sel != SEL_W'(i));
`ifdef SPIM_LSB_FIRST_EN
               lsb_d   = lsb_first;
`endif
            end
         end
         S_SETUP: begin
            cnt_d = cnt_q + 1'b1;
            if (hp_tc) begin
               cnt_d    = '0;
               state_d  = S_XFER;
               hp_d     = '0;
               edge_en  = 1'b1;
               edge_idx = '0;
            end
         end
         S_XFER: begin
            cnt_d = cnt_q + 1'b1;
            if (hp_tc) begin
               cnt_d = '0;
               if (hp_q == HP_W'(HP_LAST)) begin
                  state_d = S_HOLD;
                  sclk_d  = cpol_q;
               end else begin
                  hp_d     = hp_q + 1'b1;
                  edge_en  = 1'b1;
                  edge_idx = hp_q + 1'b1;
               end
            end
         end
         S_HOLD: begin
            cnt_d = cnt_q + 1'b1;
            if (hp_tc) begin
               cnt_d     = '0;
               state_d   = S_DONE;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               cs_n_d    = '1;
               rx_data_d = rx_sr_q;
               sclk_d    = cpol_q;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Even half-period index = leading SCLK edge, odd = trailing edge
      if (edge_en) begin
         sclk_d = ~sclk_q;
         if (edge_idx[0] == cpha_q)
            rx_sr_d = lsb_cur ? {miso, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], miso};
         if (cpha_q)
            do_shift = !edge_idx[0] && (edge_idx != '0);
         else
            do_shift = edge_idx[0] && (edge_idx != HP_W'(HP_LAST));
         if (do_shift) begin
            if (lsb_cur) begin
               tx_sr_d = tx_sr_q >> 1;
               mosi_d  = tx_sr_q[1];
            end else begin
               tx_sr_d = tx_sr_q << 1;
               mosi_d  = tx_sr_q[DATA_W-2];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         hp_q      <= '0;
         div_q     <= '0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         rx_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         cs_n_q    <= '1;
`ifdef SPIM_LSB_FIRST_EN
         lsb_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hp_q      <= hp_d;
         div_q     <= div_d;
         cpol_q    <= cpol_d;
         cpha_q    <= cpha_d;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         rx_data_q <= rx_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         cs_n_q    <= cs_n_d;
`ifdef SPIM_LSB_FIRST_EN
         lsb_q     <= lsb_d;
`endif
      end
   end

   assign rx_data = rx_data_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign sclk    = sclk_q;
   assign mosi    = mosi_q;
   assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: loopback and slave-model transfers, deselect, back-to-back, reset abort.
module tb_spi_master_param;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned NUM_SLAVES = 3;
   localparam int unsigned SEL_W      = 2;
   localparam int unsigned DIV_W      = 8;

   logic                  clk       = 1'b0;
   logic                  reset     = 1'b1;
   logic                  start     = 1'b0;
   logic                  cpol      = 1'b0;
   logic                  cpha      = 1'b0;
   logic [SEL_W-1:0]      slave_sel = '0;
   logic [DIV_W-1:0]      clk_div   = '0;
   logic [DATA_W-1:0]     tx_data   = '0;
   logic [DATA_W-1:0]     rx_data;
   logic                  busy, done, sclk, mosi, miso;
   logic [NUM_SLAVES-1:0] cs_n;
`ifdef SPIM_LSB_FIRST_EN
   logic                  lsb_first = 1'b0;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int cyc;
   logic any_cs_low;
   logic any_done;

   logic       loop_mode  = 1'b1;
   logic [7:0] slave_word = 8'h00;
   logic [7:0] slv_sr     = 8'h00;
   logic       slv_out    = 1'b0;
   logic       sclk_prev  = 1'b0;
   int         rise_cnt   = 0;
   logic [7:0] mosi_cap   = 8'h00;

   spi_master_param #(
      .DATA_W(DATA_W), .NUM_SLAVES(NUM_SLAVES), .SEL_W(SEL_W), .DIV_W(DIV_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .cpol(cpol), .cpha(cpha),
      .slave_sel(slave_sel), .clk_div(clk_div), .tx_data(tx_data),
`ifdef SPIM_LSB_FIRST_EN
      .lsb_first(lsb_first),
`endif
      .rx_data(rx_data), .busy(busy), .done(done), .sclk(sclk),
      .mosi(mosi), .miso(miso), .cs_n(cs_n)
   );

   always #5 clk = ~clk;

   assign miso = loop_mode ? mosi : slv_out;

   // SCLK monitor (rising edges, mosi at rising edges) and a CPHA=1 slave that drives on falling SCLK
   always @(posedge clk) begin
      sclk_prev <= sclk;
      if (start && !busy) begin
         rise_cnt <= 0;
         mosi_cap <= 8'h00;
      end else if (!(&cs_n) && !sclk_prev && sclk) begin
         rise_cnt <= rise_cnt + 1;
         mosi_cap <= {mosi_cap[6:0], mosi};
      end
      if (&cs_n) begin
         slv_sr <= slave_word;
      end else if (sclk_prev && !sclk) begin
         slv_out <= slv_sr[7];
         slv_sr  <= {slv_sr[6:0], 1'b0};
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns at the first negedge after the edge that accepted start
   task automatic begin_xfer(input logic p_cpol, input logic p_cpha, input logic [1:0] p_sel,
                             input logic [7:0] p_div, input logic [7:0] p_tx, input logic hold);
      cpol      = p_cpol;
      cpha      = p_cpha;
      slave_sel = p_sel;
      clk_div   = p_div;
      tx_data   = p_tx;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      cyc        = 1;
      any_cs_low = !(&cs_n);
      while (done !== 1'b1 && cyc < lim) begin
         @(negedge clk);
         cyc++;
         if (!(&cs_n) && done !== 1'b1) any_cs_low = 1'b1;
      end
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      check("rst_rx",   32'(rx_data), 32'h0);
      check("rst_busy", 32'(busy),    32'h0);
      check("rst_done", 32'(done),    32'h0);
      check("rst_sclk", 32'(sclk),    32'h0);
      check("rst_mosi", 32'(mosi),    32'h0);
      check("rst_csn",  32'(cs_n),    32'h7);
      reset = 1'b0;
      @(negedge clk);

      // mode 0, clk_div=0, slave 0, loopback 0xA5
      loop_mode = 1'b1;
      begin_xfer(1'b0, 1'b0, 2'd0, 8'd0, 8'hA5, 1'b0);
      check("m0_busy",  32'(busy), 32'h1);
      check("m0_csn",   32'(cs_n), 32'h6);
      check("m0_sclk",  32'(sclk), 32'h0);
      check("m0_mosi0", 32'(mosi), 32'h1);
      wait_done(100);
      check("m0_cyc",   32'(cyc),      32'd19);
      check("m0_rx",    32'(rx_data),  32'hA5);
      check("m0_bsy_d", 32'(busy),     32'h0);
      check("m0_csn_d", 32'(cs_n),     32'h7);
      check("m0_rises", 32'(rise_cnt), 32'd8);
      check("m0_mosi",  32'(mosi_cap), 32'hA5);
      @(negedge clk);
      check("m0_pulse", 32'(done),     32'h0);

      // mode 3, clk_div=3, slave 2, slave returns 0xC3
      loop_mode  = 1'b0;
      slave_word = 8'hC3;
      begin_xfer(1'b1, 1'b1, 2'd2, 8'd3, 8'h3C, 1'b0);
      check("m3_csn",   32'(cs_n),    32'h3);
      check("m3_sclk",  32'(sclk),    32'h1);
      check("m3_rxhld", 32'(rx_data), 32'hA5);
      wait_done(200);
      check("m3_cyc",   32'(cyc),      32'd73);
      check("m3_rx",    32'(rx_data),  32'hC3);
      check("m3_mosi",  32'(mosi_cap), 32'h3C);
      check("m3_rises", 32'(rise_cnt), 32'd8);
      check("m3_idle",  32'(sclk),     32'h1);
      @(negedge clk);
      check("m3_pulse", 32'(done),     32'h0);

      // deselect transfer: slave_sel=3
      loop_mode = 1'b1;
      begin_xfer(1'b0, 1'b0, 2'd3, 8'd0, 8'h5A, 1'b0);
      check("ds_busy",  32'(busy), 32'h1);
      wait_done(100);
      check("ds_cyc",   32'(cyc),        32'd19);
      check("ds_cslow", 32'(any_cs_low), 32'h0);
      check("ds_rx",    32'(rx_data),    32'h5A);

      // start held high: ignored while busy, re-accepted in the done cycle
      begin_xfer(1'b0, 1'b0, 2'd1, 8'd0, 8'h96, 1'b1);
      check("bb_csn1",  32'(cs_n), 32'h5);
      tx_data = 8'h69;
      wait_done(100);
      check("bb_cyc1",  32'(cyc),     32'd19);
      check("bb_rx1",   32'(rx_data), 32'h96);
      check("bb_gap",   32'(busy),    32'h0);
      @(negedge clk);
      start = 1'b0;
      check("bb_busy2", 32'(busy), 32'h1);
      check("bb_done2", 32'(done), 32'h0);
      check("bb_csn2",  32'(cs_n), 32'h5);
      wait_done(100);
      check("bb_cyc2",  32'(cyc),     32'd19);
      check("bb_rx2",   32'(rx_data), 32'h69);
      @(negedge clk);

      // clk_div all ones: H = 256
      begin_xfer(1'b0, 1'b0, 2'd0, 8'hFF, 8'h81, 1'b0);
      wait_done(6000);
      check("dmax_cyc", 32'(cyc),      32'd4609);
      check("dmax_rx",  32'(rx_data),  32'h81);
      check("dmax_rs",  32'(rise_cnt), 32'd8);
      @(negedge clk);

      // reset in the middle of a mode 1 transfer
      begin_xfer(1'b0, 1'b1, 2'd0, 8'd1, 8'hFF, 1'b0);
      repeat (15) @(negedge clk);
      check("ra_busy0", 32'(busy), 32'h1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("ra_busy",  32'(busy),    32'h0);
      check("ra_csn",   32'(cs_n),    32'h7);
      check("ra_sclk",  32'(sclk),    32'h0);
      check("ra_done",  32'(done),    32'h0);
      check("ra_rx",    32'(rx_data), 32'h0);
      any_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) any_done = 1'b1;
      end
      check("ra_nodone", 32'(any_done), 32'h0);

      // idle sclk follows cpol input
      cpol = 1'b1;
      @(negedge clk);
      check("idle_cpol", 32'(sclk), 32'h1);
      cpol = 1'b0;
      @(negedge clk);

`ifdef SPIM_LSB_FIRST_EN
      lsb_first = 1'b1;
      begin_xfer(1'b0, 1'b0, 2'd0, 8'd0, 8'h01, 1'b0);
      lsb_first = 1'b0;
      check("lsb_mosi0", 32'(mosi), 32'h1);
      wait_done(100);
      check("lsb_cyc",  32'(cyc),      32'd19);
      check("lsb_rx",   32'(rx_data),  32'h01);
      check("lsb_cap",  32'(mosi_cap), 32'h80);
      @(negedge clk);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
